// File: rtl/int_sequencer.sv
// int_sequencer: priority interrupt controller in front of the CPU INT input.
// Synchronizes raw lines, tracks pending per source (edge or level), masks,
// picks the lowest-index eligible source and holds one request until the CPU
// accepts it, then blocks further requests until eret.
//
// Handshake: int_req is a held request. Once high it stays high, with int_id
// and int_vector frozen, until the cycle in which int_ack is sampled high.
// int_ack outside REQ and eret outside SERVICE are ignored.
module int_sequencer #(
    parameter int          N_SRC      = 8,
    parameter logic [31:0] VEC_BASE   = 32'h0000_0004,
    parameter int          VEC_STRIDE = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_SRC-1:0] irq_in,
    input  logic             cfg_we,
    input  logic [1:0]       cfg_addr,
    input  logic [31:0]      cfg_wdata,
    output logic [31:0]      cfg_rdata,
    output logic             int_req,
    input  logic             int_ack,
    input  logic             eret,
    output logic [3:0]       int_id,
    output logic [31:0]      int_vector,
    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_SERVICE = 2'd2
    } state_t;

    state_t           state, state_next;
    logic [N_SRC-1:0] sync1, sync2, prev;
    logic [N_SRC-1:0] mask, pending, edge_sel;
    logic [N_SRC-1:0] eligible, edge_set, w1c, ack_clr, pending_next;
    logic             ie, ie_next;
    logic [3:0]       id_next, winner;
    logic             ack_fire;
    logic             unused_wdata;

    assign unused_wdata = ^cfg_wdata;

    // Two-flop synchronizer plus one-cycle history for rising-edge detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= '0;
            sync2 <= '0;
            prev  <= '0;
        end else begin
            sync1 <= irq_in;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign eligible = pending & mask;
    assign edge_set = sync2 & ~prev;
    assign w1c      = (cfg_we && cfg_addr == 2'd1) ? cfg_wdata[N_SRC-1:0] : '0;

    // Lowest set index wins; scanning downward lets the lowest index overwrite.
    always_comb begin
        winner = 4'd0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (eligible[i]) winner = 4'(i);
        end
    end

    // Next state, request latch and IE update.
    always_comb begin
        state_next = state;
        id_next    = int_id;
        ie_next    = ie;
        ack_fire   = 1'b0;
        case (state)
            S_IDLE: begin
                if (ie && (eligible != '0)) begin
                    state_next = S_REQ;
                    id_next    = winner;
                end
            end
            S_REQ: begin
                if (int_ack) begin
                    state_next = S_SERVICE;
                    ie_next    = 1'b0;
                    ack_fire   = 1'b1;
                end
            end
            S_SERVICE: begin
                if (eret) begin
                    state_next = S_IDLE;
                    ie_next    = 1'b1;
                end
            end
            default: state_next = S_IDLE;
        endcase
        // Software may only change IE while nothing is requested or in service.
        if (cfg_we && cfg_addr == 2'd3 && state == S_IDLE) ie_next = cfg_wdata[0];
    end

    // Acceptance clears only the accepted source; a same-cycle edge still sets it.
    always_comb begin
        ack_clr = '0;
        for (int i = 0; i < N_SRC; i++) begin
            ack_clr[i] = ack_fire && (int_id == 4'(i));
        end
        pending_next = (edge_sel & ((pending & ~(w1c | ack_clr)) | edge_set))
                     | (~edge_sel & sync2);
    end

    // Controller state, configuration and pending registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            int_id   <= 4'd0;
            ie       <= 1'b1;
            mask     <= '0;
            edge_sel <= '0;
            pending  <= '0;
        end else begin
            state   <= state_next;
            int_id  <= id_next;
            ie      <= ie_next;
            pending <= pending_next;
            if (cfg_we && cfg_addr == 2'd0) mask     <= cfg_wdata[N_SRC-1:0];
            if (cfg_we && cfg_addr == 2'd2) edge_sel <= cfg_wdata[N_SRC-1:0];
        end
    end

    // Register read mux; unused bits read as zero.
    always_comb begin
        cfg_rdata = 32'd0;
        case (cfg_addr)
            2'd0: cfg_rdata = 32'(mask);
            2'd1: cfg_rdata = 32'(pending);
            2'd2: cfg_rdata = 32'(edge_sel);
            2'd3: cfg_rdata = {24'd0, int_id, 2'b00, (state == S_SERVICE), ie};
            default: cfg_rdata = 32'd0;
        endcase
    end

    assign int_req    = (state == S_REQ);
    assign int_vector = VEC_BASE + 32'(int_id) * 32'(VEC_STRIDE);
    assign state_dbg  = state;

endmodule
